// File: rtl/coin_tally_pkg.sv
// coin_tally_pkg: shared definitions for the coin tally block.
//   - coin values in cents (1/5/10/25) via coin_value()
//   - channel indices (penny..quarter = 0..3)
//   - per-channel debounce FSM state enum
//   - default debounce length (1 ms at 30 MHz)
package coin_tally_pkg;

    localparam int DEBOUNCE_DEFAULT = 30000;
    localparam int NUM_CH           = 4;

    localparam int CH_PENNY   = 0;
    localparam int CH_NICKEL  = 1;
    localparam int CH_DIME    = 2;
    localparam int CH_QUARTER = 3;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ARMING,
        ST_BROKEN,
        ST_RELEASING
    } deb_state_t;

    function automatic logic [5:0] coin_value(input int ch);
        case (ch)
            CH_PENNY:  return 6'd1;
            CH_NICKEL: return 6'd5;
            CH_DIME:   return 6'd10;
            default:   return 6'd25;
        endcase
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: one beam channel -- 2-flop synchronizer, 4-state debounce
// FSM and debounce counter.
//   clock    : system clock
//   reset    : synchronous, active-low
//   beam_raw : asynchronous beam-broken level (1 = broken)
//   accept   : registered one-cycle pulse when a coin is accepted
module coin_debounce
    import coin_tally_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic beam_raw,
    output logic accept
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    deb_state_t    state;
    logic [CW-1:0] cnt;

    assign level = sync[1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync   <= '0;
            state  <= ST_CLEAR;
            cnt    <= '0;
            accept <= 1'b0;
        end else begin
            sync   <= {sync[0], beam_raw};
            accept <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (level) begin
                        state <= ST_ARMING;
                        cnt   <= CW'(1);
                    end
                end
                ST_ARMING: begin
                    if (!level) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state  <= ST_BROKEN;
                        cnt    <= '0;
                        accept <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BROKEN: begin
                    // Beam stays broken: coin already counted, stay silent.
                    if (!level) begin
                        state <= ST_RELEASING;
                        cnt   <= CW'(1);
                    end
                end
                ST_RELEASING: begin
                    // Bounce on release returns to BROKEN, never re-arms.
                    if (level) begin
                        state <= ST_BROKEN;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/coin_tally.sv
// coin_tally: four debounced coin beams feeding saturating per-denomination
// counters and a saturating running total in cents.
//   clock          : system clock
//   reset          : synchronous, active-low; overrides clear and accepts
//   beam_raw[3:0]  : async beam levels (penny, nickel, dime, quarter)
//   clear          : one-cycle request to zero counts and total
//   coin_event     : one-cycle pulse when any coin is accepted
//   coin_mask[3:0] : denominations accepted in the coin_event cycle
//   total_cents    : running total (saturating)
//   count_*        : per-denomination accepted counts (saturating)
module coin_tally
    import coin_tally_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       beam_raw,
    input  logic             clear,
    output logic             coin_event,
    output logic [3:0]       coin_mask,
    output logic [31:0]      total_cents,
    output logic [CNT_W-1:0] count_penny,
    output logic [CNT_W-1:0] count_nickel,
    output logic [CNT_W-1:0] count_dime,
    output logic [CNT_W-1:0] count_quarter
);

    logic [NUM_CH-1:0]             accept;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_d;
    logic [31:0]                   total_q;
    logic [31:0]                   total_d;
    logic [5:0]                    add_cents;
    logic [32:0]                   sum;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock   (clock),
            .reset   (reset),
            .beam_raw(beam_raw[g]),
            .accept  (accept[g])
        );
    end

    // clear zeroes first, then this cycle's accepts are applied on top.
    always_comb begin
        add_cents = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) add_cents = add_cents + coin_value(i);
        end
        sum     = {1'b0, (clear ? 32'd0 : total_q)} + {27'd0, add_cents};
        total_d = sum[32] ? '1 : sum[31:0];
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = clear ? '0 : cnt_q[i];
            if (accept[i] && (cnt_d[i] != '1)) cnt_d[i] = cnt_d[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            coin_event <= 1'b0;
            coin_mask  <= '0;
            total_q    <= '0;
            cnt_q      <= '0;
        end else begin
            coin_event <= |accept;
            coin_mask  <= accept;
            total_q    <= total_d;
            cnt_q      <= cnt_d;
        end
    end

    assign total_cents   = total_q;
    assign count_penny   = cnt_q[CH_PENNY];
    assign count_nickel  = cnt_q[CH_NICKEL];
    assign count_dime    = cnt_q[CH_DIME];
    assign count_quarter = cnt_q[CH_QUARTER];

endmodule

// File: tb/tb_coin_tally.sv
// Directed bench for coin_tally with DEBOUNCE_CYCLES=4. Counter width is
// reduced to 4 bits so count saturation is reachable in a short run.
module tb_coin_tally;

    localparam int DEB = 4;
    localparam int CW  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    beam_raw = 4'b0;
    logic          clear = 1'b0;
    logic          coin_event;
    logic [3:0]    coin_mask;
    logic [31:0]   total_cents;
    logic [CW-1:0] count_penny, count_nickel, count_dime, count_quarter;

    coin_tally #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .beam_raw     (beam_raw),
        .clear        (clear),
        .coin_event   (coin_event),
        .coin_mask    (coin_mask),
        .total_cents  (total_cents),
        .count_penny  (count_penny),
        .count_nickel (count_nickel),
        .count_dime   (count_dime),
        .count_quarter(count_quarter)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] beam;
        int         hold;      // rising edges the beam is sampled high
        int         events;    // expected coin_event count in the window
        int         ev_cycle;  // edge index of the event, -1 if none
        logic [3:0] mask;
    } vec_t;

    vec_t vecs[4];
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_total = 0;
    int   exp_cnt[4] = '{0, 0, 0, 0};
    int   val[4] = '{1, 5, 10, 25};

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_state(input string tag);
        check({tag, " total_cents"},   total_cents,   32'(exp_total));
        check({tag, " count_penny"},   32'(count_penny),   32'(exp_cnt[0]));
        check({tag, " count_nickel"},  32'(count_nickel),  32'(exp_cnt[1]));
        check({tag, " count_dime"},    32'(count_dime),    32'(exp_cnt[2]));
        check({tag, " count_quarter"}, 32'(count_quarter), 32'(exp_cnt[3]));
    endtask

    // Apply mask as accepted coins to the bench's own expected state.
    task automatic model_accept(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                exp_total += val[i];
                if (exp_cnt[i] < (1 << CW) - 1) exp_cnt[i]++;
            end
        end
    endtask

    task automatic model_zero();
        exp_total = 0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    endtask

    // Beam high from edge 0 to edge hold-1; observe edges 0..win-1.
    task automatic run_coin(input logic [3:0] beam, input int hold, input int win,
                            output int events, output int ev_cycle, output logic [3:0] mask);
        events = 0; ev_cycle = -1; mask = 4'b0;
        beam_raw = beam;
        for (int t = 0; t < win; t++) begin
            if (t == hold) beam_raw = 4'b0;
            tick();
            if (coin_event) begin
                if (events == 0) begin
                    ev_cycle = t;
                    mask = coin_mask;
                end
                events++;
            end
        end
        beam_raw = 4'b0;
    endtask

    initial begin
        int ev, evc, ne;
        logic [3:0] m;

        vecs[0] = '{4'b1000, 20, 1, 6,  4'b1000};   // quarter held
        vecs[1] = '{4'b0001, 3,  0, -1, 4'b0000};   // short penny glitch
        vecs[2] = '{4'b0110, 10, 1, 6,  4'b0110};   // dime+nickel together
        vecs[3] = '{4'b0100, 1,  0, -1, 4'b0000};   // one-cycle dime glitch

        // Reset state
        reset = 1'b0;
        tick(); tick();
        check("reset coin_event", 32'(coin_event), 32'd0);
        check("reset coin_mask",  32'(coin_mask),  32'd0);
        check_state("reset");
        reset = 1'b1;
        tick();

        foreach (vecs[k]) begin
            run_coin(vecs[k].beam, vecs[k].hold, vecs[k].hold + 12, ev, evc, m);
            check($sformatf("vec%0d events", k),   32'(ev),  32'(vecs[k].events));
            check($sformatf("vec%0d ev_cycle", k), 32'(evc), 32'(vecs[k].ev_cycle));
            check($sformatf("vec%0d mask", k),     32'(m),   32'(vecs[k].mask));
            model_accept(vecs[k].mask);
            check_state($sformatf("vec%0d", k));
        end

        // Clear in the same cycle as a penny accept (total was 40).
        beam_raw = 4'b0001;
        repeat (6) tick();          // after edge 5: accept pulse is live
        clear = 1'b1;
        tick();                     // edge 6
        clear = 1'b0;
        check("clr+acc coin_event", 32'(coin_event), 32'd1);
        check("clr+acc coin_mask",  32'(coin_mask),  32'b0001);
        model_zero();
        model_accept(4'b0001);
        check_state("clr+acc");
        beam_raw = 4'b0;
        ne = 0;
        repeat (12) begin
            tick();
            if (coin_event) ne++;
        end
        check("after clr extra events", 32'(ne), 32'd0);
        check_state("after clr");

        // Clear mid-debounce must not lose the coin.
        beam_raw = 4'b0010;
        repeat (3) tick();          // after edge 2: nickel arming
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        check_state("clr mid-deb");
        ne = 0;
        for (int t = 4; t < 20; t++) begin
            if (t == 10) beam_raw = 4'b0;
            tick();
            if (coin_event) ne++;
        end
        check("clr mid-deb events", 32'(ne), 32'd1);
        model_accept(4'b0010);
        check_state("clr mid-deb");

        // Minimum accepted pulse: exactly DEB synchronized high cycles.
        run_coin(4'b0001, 4, 16, ev, evc, m);
        check("min pulse events", 32'(ev),  32'd1);
        check("min pulse cycle",  32'(evc), 32'd6);
        model_accept(4'b0001);
        check_state("min pulse");

        // Drive penny count to all-ones, then one more must saturate.
        repeat (14) begin
            run_coin(4'b0001, 4, 16, ev, evc, m);
            model_accept(4'b0001);
        end
        check("penny at max", 32'(count_penny), 32'hF);
        run_coin(4'b0001, 4, 16, ev, evc, m);
        check("sat penny event", 32'(ev), 32'd1);
        model_accept(4'b0001);
        check_state("sat penny");

        // Reset during quarter ARMING, beam kept high.
        beam_raw = 4'b1000;
        repeat (3) tick();          // after edge 2: ARMING
        reset = 1'b0;
        tick();                     // edge 3 resets
        reset = 1'b1;
        model_zero();
        check("mid-reset coin_event", 32'(coin_event), 32'd0);
        check_state("mid-reset");
        ne = 0; evc = -1;
        for (int t = 4; t < 30; t++) begin
            if (t == 16) beam_raw = 4'b0;
            tick();
            if (coin_event) begin
                ne++;
                if (evc < 0) evc = t;
            end
        end
        check("post-reset events", 32'(ne),  32'd1);
        check("post-reset cycle",  32'(evc), 32'd10);
        model_accept(4'b1000);
        check_state("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/coin_tally.md
COIN_TALLY -- requirements
Module: coin_tally

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 30000, meaning consecutive stable cycles required to accept a beam level (1 ms at 30 MHz).
REQ-002 Parameter CNT_W, default 16, meaning width of each per-denomination coin counter.
REQ-003 clock  input  1  the single system clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 beam_raw  input  4  asynchronous beam-broken levels, 1 = broken: bit0 penny, bit1 nickel, bit2 dime, bit3 quarter.
REQ-006 clear  input  1  one-cycle synchronous request to zero all counters and the total (driven from an MMIO write).
REQ-007 coin_event  output  1  one-cycle pulse when one or more coins are accepted.
REQ-008 coin_mask  output  4  denominations accepted in the coin_event cycle; 0 otherwise.
REQ-009 total_cents  output  32  running value in cents.
REQ-010 count_penny, count_nickel, count_dime, count_quarter  output  CNT_W each  accepted coin counts.

Function
REQ-011 Each beam_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL run a 4-state FSM: CLEAR, ARMING, BROKEN, RELEASING.
REQ-013 CLEAR: synchronized level 1 -> ARMING with counter=1; else stay.
REQ-014 ARMING: level 0 -> CLEAR; level 1 and counter=DEBOUNCE_CYCLES-1 -> BROKEN and accept the coin; else increment the counter.
REQ-015 BROKEN: level 0 -> RELEASING with counter=1; else stay; no further events while broken.
REQ-016 RELEASING: level 1 -> BROKEN; level 0 and counter=DEBOUNCE_CYCLES-1 -> CLEAR; else increment the counter.
REQ-017 Latency: if beam_raw is held at 1, coin_event SHALL assert exactly DEBOUNCE_CYCLES+2 cycles after the first rising edge that samples it at 1.
REQ-018 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event.
REQ-019 Coins accepted in the same cycle on several channels SHALL all be counted. A single coin_event SHALL be raised, with coin_mask carrying every accepted bit.
REQ-020 In an accept cycle, total_cents SHALL increase by the sum of 1/5/10/25 over the accepted channels, and each accepted count SHALL increase by 1.
REQ-021 Each count SHALL saturate at all-ones. total_cents SHALL saturate at 32'hFFFFFFFF with no wrap.
REQ-022 On clear, all counts and total_cents SHALL become 0 the next cycle. A same-cycle accept SHALL be applied after the zeroing: count=1, total=value of that coin.
REQ-023 clear SHALL NOT affect FSM states or synchronizers; a coin mid-debounce SHALL still be accepted later.
REQ-024 Outputs SHALL be registered; no combinational path from beam_raw or clear to any output.

Reset
REQ-025 With reset=0 at a rising edge: all FSMs SHALL go to CLEAR, all synchronizers and debounce counters to 0, coin_event=0, coin_mask=0, total_cents=0, and all counts=0.
REQ-026 Reset asserted mid-debounce SHALL discard the partial coin. After release, a beam still held at 1 SHALL be re-debounced from CLEAR and counted once.
REQ-027 reset SHALL override clear and all accepts in the same cycle.

Structure
REQ-028 A shared package SHALL hold: coin values 1/5/10/25, channel indices 0-3, the FSM state enum, and the DEBOUNCE_CYCLES default.
REQ-029 Per-channel synchronizer, FSM and debounce counter SHALL be one sub-module, coin_debounce, instantiated 4 times. It outputs a one-cycle accept pulse.
REQ-030 Counter width for debounce SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-031 Quarter held high 20 cycles -> exactly one coin_event at cycle 6, coin_mask=4'b1000, total_cents=25, count_quarter=1.
REQ-032 Penny pulses 3 cycles high, then low -> no coin_event; total_cents stays 0.
REQ-033 Dime and nickel rise on the same edge and are held -> one coin_event, coin_mask=4'b0110, total_cents=15.
REQ-034 total_cents=40; clear issued in the same cycle as a penny accept -> next cycle total_cents=1, count_penny=1, other counts 0.
REQ-035 Preload count_penny=16'hFFFF, then one penny -> count stays 16'hFFFF, total_cents increments by 1.
REQ-036 reset=0 for 1 cycle during quarter ARMING, beam held -> totals 0 after reset, one quarter counted DEBOUNCE_CYCLES+2 cycles after reset release.
